// File: rtl/banco_writeback_pkg.sv
// rtl/banco_writeback_pkg.sv - shared widths and register-zero constant for the register-bank write path
package banco_writeback_pkg;

  localparam int BANCO_DATA_W = 32;
  localparam int BANCO_ADDR_W = 5;
  localparam int BANCO_DEPTH  = 4;
  localparam int REG_ZERO     = 0;

  // Register 0 is hard-wired zero in RegistradorBanco, so writes to it are meaningless.
  function automatic logic isZeroReg(input logic [BANCO_ADDR_W-1:0] regIdx);
    return regIdx == BANCO_ADDR_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/banco_writeback_if.sv
// rtl/banco_writeback_if.sv - result sources, bank write port and hazard query of the writeback driver
interface banco_writeback_if
  import banco_writeback_pkg::*;
#(
  parameter int DATA_W = BANCO_DATA_W,
  parameter int ADDR_W = BANCO_ADDR_W
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] writeRegistrador;
  logic [DATA_W-1:0] writeData;
  logic              we;
  logic [ADDR_W-1:0] query_reg;
  logic              query_hit;
  logic              pending;

  // Producer / consumer side (ALU, load unit, operand fetch, register bank)
  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, query_reg,
    input  alu_ready, mem_ready, writeRegistrador, writeData, we, query_hit, pending
  );

  // Writeback driver side
  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, query_reg,
    output alu_ready, mem_ready, writeRegistrador, writeData, we, query_hit, pending
  );
endinterface

// File: rtl/banco_writeback_wb_fifo.sv
// rtl/banco_writeback_wb_fifo.sv - small {reg,data} FIFO with per-entry taps for hazard lookup
module wb_fifo #(
  parameter int WIDTH  = 37,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              pushData,
  output logic [WIDTH-1:0]              headData,
  output logic                          full,
  output logic                          empty,
  output logic [PTR_W:0]                count,
  output logic [DEPTH-1:0]              entryValid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entryReg
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wrPtr;
  logic [PTR_W-1:0]            rdPtr;

  assign full     = count == (PTR_W+1)'(DEPTH);
  assign empty    = count == '0;
  assign headData = mem[rdPtr];

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : gTap
    assign entryValid[g] = {1'b0, PTR_W'(g) - rdPtr} < count;
    assign entryReg[g]   = mem[g][WIDTH-1 -: ADDR_W];
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: stale slots are masked by entryValid.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/banco_writeback.sv
// rtl/banco_writeback.sv - arbitrates ALU/load results into a FIFO and drives one bank write per cycle
module banco_writeback
  import banco_writeback_pkg::*;
#(
  parameter int DATA_W = BANCO_DATA_W,
  parameter int ADDR_W = BANCO_ADDR_W,
  parameter int DEPTH  = BANCO_DEPTH
) (
  input logic              clock,
  input logic              reset,
  banco_writeback_if.slave bus
);
  localparam int WIDTH = ADDR_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);

  logic                         full;
  logic                         empty;
  logic [PTR_W:0]               count;
  logic [DEPTH-1:0]             entryValid;
  logic [DEPTH-1:0][ADDR_W-1:0] entryReg;
  logic [WIDTH-1:0]             headData;
  logic [WIDTH-1:0]             pushData;
  logic                         memAccept;
  logic                         aluAccept;
  logic                         push;
  logic                         pop;
  logic                         fifoHit;

  // Load results have fixed priority; full is taken from the registered count only.
  assign bus.mem_ready = !reset && !full;
  assign bus.alu_ready = !reset && !full && !bus.mem_valid;
  assign memAccept     = bus.mem_valid && bus.mem_ready;
  assign aluAccept     = bus.alu_valid && bus.alu_ready;

  // Accepted transfers to register 0 complete the handshake but are dropped here.
  always_comb begin
    push     = 1'b0;
    pushData = {bus.alu_reg, bus.alu_data};
    if (memAccept) begin
      push     = bus.mem_reg != ADDR_W'(REG_ZERO);
      pushData = {bus.mem_reg, bus.mem_data};
    end else if (aluAccept) begin
      push     = bus.alu_reg != ADDR_W'(REG_ZERO);
    end
  end

  assign pop = !empty;

  wb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) uFifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .pushData   (pushData),
    .headData   (headData),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .entryValid (entryValid),
    .entryReg   (entryReg)
  );

  // Registered bank write port: head moves to the output each non-empty cycle, else hold addr/data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.we               <= 1'b0;
      bus.writeRegistrador <= '0;
      bus.writeData        <= '0;
    end else if (pop) begin
      bus.we               <= 1'b1;
      bus.writeRegistrador <= headData[WIDTH-1 -: ADDR_W];
      bus.writeData        <= headData[DATA_W-1:0];
    end else begin
      bus.we               <= 1'b0;
    end
  end

  // Hazard lookup across every live FIFO slot.
  always_comb begin
    fifoHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && entryReg[i] == bus.query_reg) fifoHit = 1'b1;
    end
  end

  assign bus.query_hit = (bus.query_reg != ADDR_W'(REG_ZERO)) &&
                         (fifoHit || (bus.we && bus.writeRegistrador == bus.query_reg));
  assign bus.pending   = (count != '0) || bus.we;
endmodule

// File: tb/tb_banco_writeback.sv
// tb/tb_banco_writeback.sv - directed and randomized checks of banco_writeback against a queue model
module tb_banco_writeback;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;

  banco_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  banco_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference: pending writes in acceptance order plus the bank write port.
  entry_t            modelQ[$];
  logic              outWe;
  logic [ADDR_W-1:0] outReg;
  logic [DATA_W-1:0] outData;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelHit(input logic [ADDR_W-1:0] q);
    logic hit;
    hit = outWe && outReg == q;
    foreach (modelQ[i]) if (modelQ[i].r == q) hit = 1'b1;
    return (q != '0) && hit;
  endfunction

  task automatic checkOutputs();
    check("we", 64'(bus.we), 64'(outWe));
    check("writeRegistrador", 64'(bus.writeRegistrador), 64'(outReg));
    check("writeData", 64'(bus.writeData), 64'(outData));
    check("pending", 64'(bus.pending), 64'((modelQ.size() != 0) || outWe));
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
  task automatic step();
    logic fullM, memAcc, aluAcc;
    entry_t e;
    @(negedge clock);
    fullM  = modelQ.size() == DEPTH;
    memAcc = bus.mem_valid && !fullM;
    aluAcc = bus.alu_valid && !fullM && !bus.mem_valid;
    check("mem_ready", 64'(bus.mem_ready), 64'(!fullM));
    check("alu_ready", 64'(bus.alu_ready), 64'(!fullM && !bus.mem_valid));
    check("query_hit", 64'(bus.query_hit), 64'(modelHit(bus.query_reg)));
    @(posedge clock);
    if (modelQ.size() != 0) begin
      e = modelQ.pop_front();
      outWe = 1'b1;
      outReg = e.r;
      outData = e.d;
    end else begin
      outWe = 1'b0;
    end
    if (memAcc && bus.mem_reg != '0) begin
      e.r = bus.mem_reg; e.d = bus.mem_data; modelQ.push_back(e);
    end else if (aluAcc && bus.alu_reg != '0) begin
      e.r = bus.alu_reg; e.d = bus.alu_data; modelQ.push_back(e);
    end
    #1;
    checkOutputs();
    if (memAcc) bus.mem_valid = 1'b0;
    if (aluAcc) bus.alu_valid = 1'b0;
  endtask

  task automatic offerAlu(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    bus.alu_valid = 1'b1; bus.alu_reg = r; bus.alu_data = d;
  endtask

  task automatic offerMem(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    bus.mem_valid = 1'b1; bus.mem_reg = r; bus.mem_data = d;
  endtask

  task automatic modelReset();
    modelQ.delete();
    outWe = 1'b0; outReg = '0; outData = '0;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.query_reg = '0;
    modelReset();

    // Reset state
    #1;
    check("rst_we", 64'(bus.we), 64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    @(posedge clock); #3 reset = 1'b0;
    step();

    // 1. Single ALU write reg3 <- 0x2A
    offerAlu(5'd3, 32'h2A);
    step(); step(); step();

    // 2. Zero drop
    offerAlu(5'd0, 32'd2);
    step(); step(); step();

    // 3. Priority: mem(5,0x11) then alu(6,0x22)
    offerMem(5'd5, 32'h11);
    offerAlu(5'd6, 32'h22);
    step(); step(); step(); step();

    // 4. DEPTH+1 back-to-back distinct offers
    for (int i = 0; i <= DEPTH; i++) begin
      offerAlu(ADDR_W'(10 + i), 32'hA000 + 32'(i));
      step();
    end
    step(); step(); step();

    // 5. Hazard on reg 7, then on reg 0
    bus.query_reg = 5'd7;
    offerAlu(5'd7, 32'h77);
    step(); step(); step(); step();
    bus.query_reg = 5'd0;
    offerAlu(5'd7, 32'h78);
    step(); step(); step();

    // 6. Asynchronous reset mid-operation
    offerMem(5'd20, 32'h200);
    offerAlu(5'd21, 32'h210);
    step();
    #2 reset = 1'b1;
    #1;
    modelReset();
    check("arst_we", 64'(bus.we), 64'd0);
    check("arst_pending", 64'(bus.pending), 64'd0);
    check("arst_mem_ready", 64'(bus.mem_ready), 64'd0);
    check("arst_alu_ready", 64'(bus.alu_ready), 64'd0);
    check("arst_addr", 64'(bus.writeRegistrador), 64'd0);
    @(posedge clock); #3 reset = 1'b0;
    step(); step(); step();

    // Randomized traffic from both sources with hazard queries
    for (int c = 0; c < 400; c++) begin
      if (!bus.mem_valid && ($urandom_range(0, 2) == 0))
        offerMem(ADDR_W'($urandom_range(0, 7)), $urandom);
      if (!bus.alu_valid && ($urandom_range(0, 1) == 0))
        offerAlu(ADDR_W'($urandom_range(0, 7)), $urandom);
      bus.query_reg = ADDR_W'($urandom_range(0, 7));
      step();
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
